// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush/halt bundle between pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
);
    logic [STAGES-1:0] stall_req;
    logic [STAGES-1:0] flush_req;
    logic              halt_req;
    logic [STAGES-1:0] ex_signal;
    logic [STAGES-1:0] flush_signal;
    logic              halt_ack;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_total;

    modport master (
        output stall_req, flush_req, halt_req,
        input  ex_signal, flush_signal, halt_ack, stall_timeout, stall_total
    );

    modport slave (
        input  stall_req, flush_req, halt_req,
        output ex_signal, flush_signal, halt_ack, stall_timeout, stall_total
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage execute enables, registered flushes, halt/drain handshake, stall watchdog and counter
module pipe_ctrl #(
    parameter int STAGES  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    localparam int DW = $clog2(STAGES) + 1;
    localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
    localparam logic [DW-1:0] LAST = DW'(STAGES - 1);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    logic [1:0]        state, state_n;
    logic [DW-1:0]     drain_cnt;
    logic [CNT_W-1:0]  stall_run;
    logic [STAGES-1:0] others_stall, flush_mask;
    logic              any_stall;

    assign any_stall = |bus.stall_req;

    // a stage is never held back by its own request, and a flush at k clears every younger stage
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign others_stall[i] = |(bus.stall_req & ~(STAGES'(1) << i));
        assign flush_mask[i]   = |(bus.flush_req >> (i + 1));
    end

    always_comb begin
        state_n = (state == RUN) ? (bus.halt_req ? DRAIN : RUN)
                : !bus.halt_req ? RUN
                : (state == HALTED) ? HALTED
                : (state == DRAIN && !any_stall && drain_cnt + 1'b1 == LAST) ? HALTED
                : (state == DRAIN) ? DRAIN : RUN;
    end

    assign bus.ex_signal = (rst || state == HALTED) ? '0
                         : ~others_stall & (state == DRAIN ? ~STAGES'(1) : '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RUN;
            drain_cnt         <= '0;
            stall_run         <= '0;
            bus.halt_ack      <= 1'b0;
            bus.flush_signal  <= '0;
            bus.stall_timeout <= 1'b0;
            bus.stall_total   <= '0;
        end else begin
            state             <= state_n;
            drain_cnt         <= (state == RUN) ? '0 : (state == DRAIN && !any_stall) ? drain_cnt + 1'b1 : drain_cnt;
            stall_run         <= !any_stall ? '0 : (stall_run == TO) ? TO : stall_run + 1'b1;
            bus.halt_ack      <= (state_n == HALTED);
            bus.flush_signal  <= flush_mask;
            bus.stall_timeout <= bus.stall_timeout | (any_stall && stall_run >= TO - 1'b1);
            bus.stall_total   <= bus.stall_total + CNT_W'(any_stall && !(&bus.stall_total));
        end
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit replacing the fixed four-stage stall combiner. Combines per-stage stall requests into per-stage execute enables for STAGES stages, and adds registered flush distribution, a halt/drain handshake for external debug or reset sequencing, a stall watchdog and a stall-cycle counter. Sits between the pipeline stage modules and the top-level CPU wrapper.

## Interface
Parameters:
- STAGES, 4: number of pipeline stages; stage 0 is the youngest (fetch), stage STAGES-1 the oldest. Legal range 2..16.
- CNT_W, 16: width of the stall counters.
- TIMEOUT, 1023: consecutive stall cycles that set stall_timeout; must satisfy 1 <= TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_req  in  STAGES  bit i: stage i requests a pipeline stall.
- flush_req  in  STAGES  bit k: stage k requests a flush of all younger stages (0..k-1).
- halt_req  in  1  level request to drain and freeze the pipeline.
- ex_signal  out  STAGES  bit i: stage i may advance this cycle.
- flush_signal  out  STAGES  bit j: stage j discards its contents this cycle.
- halt_ack  out  1  pipeline drained and frozen.
- stall_timeout  out  1  sticky watchdog flag.
- stall_total  out  CNT_W  saturating count of cycles with any stall_req bit set.

## Operation
- any_stall = OR of stall_req. others_stall[i] = OR of stall_req with bit i masked. A stage is never held by its own request; it stalls itself internally.
- State machine, states RUN, DRAIN, HALTED; reset to RUN.
- RUN: ex_signal[i] = ~others_stall[i]. halt_req=1 -> DRAIN, with drain_cnt cleared.
- DRAIN: ex_signal as in RUN, except ex_signal[0]=0, so no new fetch. drain_cnt, width clog2(STAGES)+1, increments on each cycle with any_stall=0. It does not reset on a stall. When drain_cnt reaches STAGES-1 on an increment -> HALTED. halt_req=0 -> RUN.
- HALTED: ex_signal all 0. halt_req=0 -> RUN.
- halt_ack is a register: 1 exactly while the state is HALTED.
- Flush: flush_mask[j] = OR over k>j of flush_req[k]. flush_signal is that mask registered, so it is a single-cycle pulse one cycle after the request. Flushes are honoured in every state. Flush does not alter ex_signal or the state machine.
- Watchdog: stall_run counts consecutive any_stall cycles and clears on any cycle with any_stall=0. It saturates at TIMEOUT. When it reaches TIMEOUT, stall_timeout is set and stays set until rst.
- stall_total increments on every any_stall cycle, in any state, and saturates at 2^CNT_W-1.

## Timing
- Reset values: state RUN, halt_ack 0, flush_signal 0, stall_timeout 0, stall_total 0, stall_run 0, drain_cnt 0.
- ex_signal is forced to 0 on every cycle with rst=1. Outside reset it is combinational from stall_req and the current state: zero latency.
- flush_signal: one-cycle latency, one-cycle width. Back-to-back flush_req cycles give back-to-back pulses.
- halt: halt_req rising at cycle t moves the state to DRAIN at t+1. With no stalls, HALTED and halt_ack=1 arrive at t+STAGES. Each stalled cycle in DRAIN adds one cycle.
- halt_req falling while HALTED: state RUN and halt_ack=0 on the next edge. ex_signal resumes that same cycle.
- stall_timeout: asserted on the edge that ends the TIMEOUT-th consecutive stall cycle.
- rst in mid-DRAIN or HALTED: back to RUN on the next edge, all flags cleared. halt_req still high after rst re-enters DRAIN on the following edge.

## Test plan
- STAGES=4, stall_req=4'b0100: ex_signal=4'b0100. Then stall_req=4'b0000: ex_signal=4'b1111.
- flush_req=4'b1000 for one cycle at t: flush_signal=4'b0111 at t+1 only, and 4'b0000 at t+2. flush_req=4'b1010: flush_signal=4'b0111.
- halt_req held high from t with no stalls: ex_signal[0]=0 from t+1, halt_ack=1 at t+4 and ex_signal=0. Drop halt_req: halt_ack=0 on the next cycle. Repeat with a 3-cycle stall during DRAIN: halt_ack at t+7.
- TIMEOUT=5, any_stall for 4 cycles, one free cycle, then 5 cycles: stall_timeout=0 after the first burst, 1 after the 5th cycle of the second burst. It stays 1 with stalls removed and clears only on rst.
- CNT_W=3 with 10 stall cycles: stall_total saturates at 7.
- rst pulsed while HALTED with halt_req=1: halt_ack=0 and state RUN after the edge. Re-halt completes STAGES cycles after rst is released.
